shift_arbiter: RTL

//  Round-robin arbiter/sequencer that shares one pipelined right-shift unit among NUM_REQ requesters.

---
 rtl/shift_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one pipelined right shifter among NUM_REQ requesters.
// Optional grant locking is compiled in by defining SHIFT_ARB_LOCK_EN.
module shift_arbiter #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned SH_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_shamt,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic                          sh_enable,
  output logic [DATA_WIDTH-1:0]         sh_a,
  output logic [DATA_WIDTH-1:0]         sh_shift_mag,
  input  logic [DATA_WIDTH-1:0]         sh_out,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          busy
);

  localparam int unsigned LOCK_MAX = 8;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_nx;
  logic [ID_W-1:0]         ptr_q, ptr_nx, ptr_adv;
  logic [SH_LAT:0]         tag_v_q;
  logic [ID_W-1:0]         tag_id_q [SH_LAT+1];
  logic                    gnt_found;
  logic [ID_W-1:0]         gnt_id;
  logic [DATA_WIDTH-1:0]   a_sel, m_sel;
  logic                    xfer;
  logic                    pipe_head_empty;

  // Two-pass search: first at or above the pointer, then wrap to the bottom.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid[j] && (ID_W'(j) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    m_sel = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == gnt_id) begin
        a_sel = req_a[j*DATA_WIDTH +: DATA_WIDTH];
        m_sel = req_shamt[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grants are withheld in reset, while draining, and in the cycle flush is raised.
  assign xfer      = rst_n && (state_q == ST_RUN) && !flush && gnt_found;
  assign req_ready = xfer ? (NUM_REQ'(1) << gnt_id) : '0;
  assign ptr_adv   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

`ifdef SHIFT_ARB_LOCK_EN
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_nx, chain_cnt;
  logic             lock_sel;

  always_comb begin
    lock_sel = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == gnt_id) lock_sel = req_lock[j];
    end
  end

  // A locked grant holds the pointer; the chain is capped at LOCK_MAX grants.
  always_comb begin
    ptr_nx      = ptr_q;
    lock_cnt_nx = lock_cnt_q;
    chain_cnt   = ((lock_cnt_q != '0) && (gnt_id == ptr_q)) ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
    if (xfer) begin
      if (lock_sel && (chain_cnt < CNT_W'(LOCK_MAX))) begin
        ptr_nx      = gnt_id;
        lock_cnt_nx = chain_cnt;
      end else begin
        ptr_nx      = ptr_adv;
        lock_cnt_nx = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt_q <= '0;
    else        lock_cnt_q <= lock_cnt_nx;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  always_comb begin
    ptr_nx = ptr_q;
    if (xfer) ptr_nx = ptr_adv;
  end
`endif

  // Drain completes once nothing remains behind the output stage.
  assign pipe_head_empty = ~|tag_v_q[SH_LAT-1:0];

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_nx = ST_DRAIN;
      ST_DRAIN: if (pipe_head_empty) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_nx;
  end

  // Issue registers, tag pipe and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      sh_enable    <= 1'b0;
      sh_a         <= '0;
      sh_shift_mag <= '0;
      tag_v_q      <= '0;
      for (int unsigned k = 0; k <= SH_LAT; k++) tag_id_q[k] <= '0;
      busy         <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      ptr_q     <= ptr_nx;
      sh_enable <= xfer;
      if (xfer) begin
        sh_a         <= a_sel;
        sh_shift_mag <= m_sel;
      end
      tag_v_q     <= {tag_v_q[SH_LAT-1:0], xfer};
      tag_id_q[0] <= gnt_id;
      for (int unsigned k = 1; k <= SH_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
      busy       <= xfer | (|tag_v_q[SH_LAT-1:0]);
      flush_done <= (state_nx == ST_DONE);
    end
  end

  assign rsp_valid = tag_v_q[SH_LAT];
  assign rsp_id    = tag_id_q[SH_LAT];
  assign rsp_data  = sh_out;

endmodule
